// File: rtl/ifu_ibuf_if.sv
// Handshake bundle between fetch, the instruction buffer and the decode stage.
// The buffer uses the slave modport; fetch/decode (or a bench) use master.
interface ifu_ibuf_if #(
    parameter int PTR_W = 3
) ();
    logic              rtu_global_flush;
    logic              y_idu_id_stall_ctrl;
    logic              ifu_ibuf_wr_vld;
    logic [63:0]       ifu_ibuf_wr_pc;
    logic [31:0]       ifu_ibuf_wr_inst;
    logic              ifu_ibuf_full;
    logic              ifu_ibuf_afull;
    logic [PTR_W:0]    ifu_ibuf_cnt;
    logic              ifu_idu_id_inst_vld;
    logic [63:0]       ifu_idu_id_inst_pc;
    logic [31:0]       ifu_idu_id_inst;

    modport master (
        output rtu_global_flush, y_idu_id_stall_ctrl,
               ifu_ibuf_wr_vld, ifu_ibuf_wr_pc, ifu_ibuf_wr_inst,
        input  ifu_ibuf_full, ifu_ibuf_afull, ifu_ibuf_cnt,
               ifu_idu_id_inst_vld, ifu_idu_id_inst_pc, ifu_idu_id_inst
    );

    modport slave (
        input  rtu_global_flush, y_idu_id_stall_ctrl,
               ifu_ibuf_wr_vld, ifu_ibuf_wr_pc, ifu_ibuf_wr_inst,
        output ifu_ibuf_full, ifu_ibuf_afull, ifu_ibuf_cnt,
               ifu_idu_id_inst_vld, ifu_idu_id_inst_pc, ifu_idu_id_inst
    );
endinterface

// File: rtl/ifu_ibuf.sv
// Circular instruction buffer between fetch and decode, emptied on global flush.
// Define IFU_IBUF_BYPASS_EN to forward a write straight to decode when the buffer is empty.
module ifu_ibuf #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst_clk,
    ifu_ibuf_if.slave   bus
);
    localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_AFULL = (PTR_W+1)'(DEPTH - 2);

    logic [95:0]      mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   cnt;
    logic             empty;
    logic             full;
    logic             byp;
    logic             push;
    logic             pop;
    logic [95:0]      head;

    always_comb begin
        empty = (cnt == '0);
        full  = (cnt == CNT_FULL);
`ifdef IFU_IBUF_BYPASS_EN
        byp   = empty & bus.ifu_ibuf_wr_vld & ~bus.rtu_global_flush;
`else
        byp   = 1'b0;
`endif
        // A bypassed instruction taken by decode this cycle never enters the array.
        push  = bus.ifu_ibuf_wr_vld & ~full & ~bus.rtu_global_flush
                & ~(byp & ~bus.y_idu_id_stall_ctrl);
        pop   = ~empty & ~bus.y_idu_id_stall_ctrl & ~bus.rtu_global_flush;
    end

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (bus.rtu_global_flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr] <= {bus.ifu_ibuf_wr_pc, bus.ifu_ibuf_wr_inst};
        end
    end

    always_comb begin
        head                   = mem[rptr];
        bus.ifu_idu_id_inst_vld = ~empty | byp;
        bus.ifu_idu_id_inst_pc  = '0;
        bus.ifu_idu_id_inst     = '0;
        if (byp) begin
            bus.ifu_idu_id_inst_pc = bus.ifu_ibuf_wr_pc;
            bus.ifu_idu_id_inst    = bus.ifu_ibuf_wr_inst;
        end else if (!empty) begin
            bus.ifu_idu_id_inst_pc = head[95:32];
            bus.ifu_idu_id_inst    = head[31:0];
        end
        bus.ifu_ibuf_full  = full;
        bus.ifu_ibuf_afull = (cnt >= CNT_AFULL);
        bus.ifu_ibuf_cnt   = cnt;
    end
endmodule

// File: tb/tb_ifu_ibuf.sv
// Self-checking bench for ifu_ibuf: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ifu_ibuf;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic clk = 1'b0;
    logic rst_clk;
    always #5 clk = ~clk;

    ifu_ibuf_if #(.PTR_W(PTR_W)) bus ();

    ifu_ibuf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk     (clk),
        .rst_clk (rst_clk),
        .bus     (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   passes = 0;
    bit   run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the buffer is just an ordered queue of accepted instructions.
    always @(posedge clk or posedge rst_clk) begin : model
        bit byp, push, pop;
        ent_t e;
        if (rst_clk) begin
            q.delete();
        end else if (bus.rtu_global_flush) begin
            q.delete();
        end else begin
`ifdef IFU_IBUF_BYPASS_EN
            byp = (q.size() == 0) && bus.ifu_ibuf_wr_vld;
`else
            byp = 1'b0;
`endif
            push = bus.ifu_ibuf_wr_vld && (q.size() < DEPTH) && !(byp && !bus.y_idu_id_stall_ctrl);
            pop  = (q.size() > 0) && !bus.y_idu_id_stall_ctrl;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.pc   = bus.ifu_ibuf_wr_pc;
                e.inst = bus.ifu_ibuf_wr_inst;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        e_vld;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        int          n;
        if (run) begin
            n      = q.size();
            e_vld  = (n > 0);
            e_pc   = (n > 0) ? q[0].pc : 64'h0;
            e_inst = (n > 0) ? q[0].inst : 32'h0;
`ifdef IFU_IBUF_BYPASS_EN
            if (n == 0 && bus.ifu_ibuf_wr_vld && !bus.rtu_global_flush && !rst_clk) begin
                e_vld  = 1'b1;
                e_pc   = bus.ifu_ibuf_wr_pc;
                e_inst = bus.ifu_ibuf_wr_inst;
            end
`endif
            chk("vld",   64'(bus.ifu_idu_id_inst_vld), 64'(e_vld));
            chk("pc",    bus.ifu_idu_id_inst_pc, e_pc);
            chk("inst",  64'(bus.ifu_idu_id_inst), 64'(e_inst));
            chk("cnt",   64'(bus.ifu_ibuf_cnt), 64'(n));
            chk("full",  64'(bus.ifu_ibuf_full), 64'(n == DEPTH));
            chk("afull", 64'(bus.ifu_ibuf_afull), 64'(n >= DEPTH - 2));
        end
    end

    initial begin
        int sent, recv, stall_left, budget;
        bit prev_stalled;
        logic [63:0] prev_pc;

        rst_clk = 1'b1;
        bus.rtu_global_flush    = 1'b0;
        bus.y_idu_id_stall_ctrl = 1'b0;
        bus.ifu_ibuf_wr_vld     = 1'b0;
        bus.ifu_ibuf_wr_pc      = '0;
        bus.ifu_ibuf_wr_inst    = '0;
        #1 run = 1;
        cyc();
        chk("rst_vld", 64'(bus.ifu_idu_id_inst_vld), 64'h0);
        chk("rst_cnt", 64'(bus.ifu_ibuf_cnt), 64'h0);
        cyc();
        rst_clk = 1'b0;
        cyc();

        // Single instruction, no stall
        bus.ifu_ibuf_wr_vld  = 1'b1;
        bus.ifu_ibuf_wr_pc   = 64'h8000_0000;
        bus.ifu_ibuf_wr_inst = 32'h0000_0513;
`ifdef IFU_IBUF_BYPASS_EN
        #1;
        chk("t1_byp_vld", 64'(bus.ifu_idu_id_inst_vld), 64'h1);
        chk("t1_byp_pc", bus.ifu_idu_id_inst_pc, 64'h8000_0000);
        cyc();
        bus.ifu_ibuf_wr_vld = 1'b0;
        #1;
        chk("t1_cnt_after", 64'(bus.ifu_ibuf_cnt), 64'h0);
`else
        cyc();
        bus.ifu_ibuf_wr_vld = 1'b0;
        #1;
        chk("t1_vld", 64'(bus.ifu_idu_id_inst_vld), 64'h1);
        chk("t1_pc", bus.ifu_idu_id_inst_pc, 64'h8000_0000);
        chk("t1_inst", 64'(bus.ifu_idu_id_inst), 64'h0000_0513);
        cyc();
        chk("t1_cnt_after", 64'(bus.ifu_ibuf_cnt), 64'h0);
        chk("t1_vld_after", 64'(bus.ifu_idu_id_inst_vld), 64'h0);
`endif

        // Fill under stall, ninth write dropped, then drain in order
        bus.y_idu_id_stall_ctrl = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.ifu_ibuf_wr_vld  = 1'b1;
            bus.ifu_ibuf_wr_pc   = 64'h1000 + 64'(4 * i);
            bus.ifu_ibuf_wr_inst = 32'(i);
            cyc();
            chk("t2_cnt",   64'(bus.ifu_ibuf_cnt),   64'((i + 1 > 8) ? 8 : i + 1));
            chk("t2_afull", 64'(bus.ifu_ibuf_afull), 64'(i + 1 >= 6));
            chk("t2_full",  64'(bus.ifu_ibuf_full),  64'(i + 1 >= 8));
        end
        bus.ifu_ibuf_wr_vld     = 1'b0;
        bus.y_idu_id_stall_ctrl = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_order", bus.ifu_idu_id_inst_pc, 64'h1000 + 64'(4 * k));
            cyc();
        end
        chk("t2_cnt_end", 64'(bus.ifu_ibuf_cnt), 64'h0);

        // Full buffer: write offered during a pop is still rejected
        bus.y_idu_id_stall_ctrl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.ifu_ibuf_wr_vld = 1'b1;
            bus.ifu_ibuf_wr_pc  = 64'h1800 + 64'(4 * i);
            cyc();
        end
        chk("t3_cnt_full", 64'(bus.ifu_ibuf_cnt), 64'h8);
        bus.y_idu_id_stall_ctrl = 1'b0;
        bus.ifu_ibuf_wr_pc      = 64'h2000;
        cyc();
        bus.ifu_ibuf_wr_vld = 1'b0;
        chk("t3_cnt_rej", 64'(bus.ifu_ibuf_cnt), 64'h7);
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("t3_order", bus.ifu_idu_id_inst_pc, 64'h1804 + 64'(4 * k));
            cyc();
        end
        chk("t3_vld_end", 64'(bus.ifu_idu_id_inst_vld), 64'h0);

        // Stream 20 with random 1-3 cycle stalls
        sent = 0; recv = 0; stall_left = 0; budget = 0;
        prev_stalled = 0; prev_pc = '0;
        while (recv < 20 && budget < 300) begin
            budget++;
            if (stall_left > 0) begin
                bus.y_idu_id_stall_ctrl = 1'b1;
                stall_left--;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.y_idu_id_stall_ctrl = 1'b1;
                stall_left = $urandom_range(0, 2);
            end else begin
                bus.y_idu_id_stall_ctrl = 1'b0;
            end
            bus.ifu_ibuf_wr_vld  = (sent < 20);
            bus.ifu_ibuf_wr_pc   = 64'h3000 + 64'(4 * sent);
            bus.ifu_ibuf_wr_inst = 32'h100 + 32'(sent);
            #1;
            if (prev_stalled && bus.ifu_idu_id_inst_vld)
                chk("t4_stall_hold", bus.ifu_idu_id_inst_pc, prev_pc);
            if (bus.ifu_idu_id_inst_vld && !bus.y_idu_id_stall_ctrl) begin
                chk("t4_order", bus.ifu_idu_id_inst_pc, 64'h3000 + 64'(4 * recv));
                recv++;
            end
            prev_stalled = bus.y_idu_id_stall_ctrl && bus.ifu_idu_id_inst_vld;
            prev_pc      = bus.ifu_idu_id_inst_pc;
            if (sent < 20 && q.size() < DEPTH) sent++;
            cyc();
        end
        chk("t4_recv_all", 64'(recv), 64'd20);
        bus.ifu_ibuf_wr_vld     = 1'b0;
        bus.y_idu_id_stall_ctrl = 1'b0;
        cyc();

        // Flush with cnt=5 and a concurrent write
        bus.y_idu_id_stall_ctrl = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.ifu_ibuf_wr_vld = 1'b1;
            bus.ifu_ibuf_wr_pc  = 64'h4000 + 64'(4 * i);
            cyc();
        end
        chk("t5_cnt5", 64'(bus.ifu_ibuf_cnt), 64'h5);
        bus.rtu_global_flush = 1'b1;
        bus.ifu_ibuf_wr_pc   = 64'h5000;
        cyc();
        bus.rtu_global_flush    = 1'b0;
        bus.ifu_ibuf_wr_vld     = 1'b0;
        bus.y_idu_id_stall_ctrl = 1'b0;
        #1;
        chk("t5_cnt0", 64'(bus.ifu_ibuf_cnt), 64'h0);
        chk("t5_vld0", 64'(bus.ifu_idu_id_inst_vld), 64'h0);
        cyc();
        chk("t5_write_lost", 64'(bus.ifu_idu_id_inst_vld), 64'h0);

        // Asynchronous reset mid-stream with cnt=3
        bus.y_idu_id_stall_ctrl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ifu_ibuf_wr_vld = 1'b1;
            bus.ifu_ibuf_wr_pc  = 64'h6000 + 64'(4 * i);
            bus.ifu_ibuf_wr_inst = 32'hA0 + 32'(i);
            cyc();
        end
        bus.ifu_ibuf_wr_vld = 1'b0;
        chk("t6_cnt3", 64'(bus.ifu_ibuf_cnt), 64'h3);
        #2 rst_clk = 1'b1;
        #1;
        chk("t6_vld",   64'(bus.ifu_idu_id_inst_vld), 64'h0);
        chk("t6_pc",    bus.ifu_idu_id_inst_pc, 64'h0);
        chk("t6_inst",  64'(bus.ifu_idu_id_inst), 64'h0);
        chk("t6_cnt",   64'(bus.ifu_ibuf_cnt), 64'h0);
        chk("t6_full",  64'(bus.ifu_ibuf_full), 64'h0);
        chk("t6_afull", 64'(bus.ifu_ibuf_afull), 64'h0);
        cyc();
        rst_clk = 1'b0;
        bus.y_idu_id_stall_ctrl = 1'b0;
        cyc();
        chk("t6_cnt_after", 64'(bus.ifu_ibuf_cnt), 64'h0);
        cyc();

        run = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
